// File: rtl/acp_pkg.sv
// acp_pkg: shared AXI3/ACP encodings, burst geometry and FSM states for the ACP stream engines.
package acp_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [2:0] AXI_SIZE_16B    = 3'b100;

    localparam logic [3:0] ACP_ARCACHE = 4'b1111;
    localparam logic [4:0] ACP_ARUSER  = 5'b00001;

    localparam int BEAT_BYTES = 16;
    localparam int PAGE_BEATS = 256;
    localparam int MAX_BURST  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ADDR,
        S_DATA,
        S_FIN
    } state_e;

endpackage

// File: rtl/acp_burst_calc.sv
// acp_burst_calc: next burst length (min of 16, remaining beats, beats left in the 4 KB page)
// and the remaining/address values after that burst completes.
module acp_burst_calc
    import acp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RW     = 11
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [RW-1:0]     rem_i,
    output logic [4:0]        blen_o,
    output logic [RW-1:0]     rem_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [8:0] page_left;
    logic [4:0] rem_cap;

    always_comb begin
        page_left = 9'(PAGE_BEATS) - {1'b0, addr_i[11:4]};
        rem_cap   = (rem_i > RW'(MAX_BURST)) ? 5'(MAX_BURST) : rem_i[4:0];
        // page_left only wins when it is <= 16, so its low 5 bits are exact
        blen_o    = ({4'b0, rem_cap} < page_left) ? rem_cap : page_left[4:0];
        rem_o     = rem_i - RW'(blen_o);
        addr_o    = addr_i + ADDR_W'(blen_o) * ADDR_W'(BEAT_BYTES);
    end

endmodule

// File: rtl/acp_read_to_bram.sv
// acp_read_to_bram: AXI3 read master that copies a contiguous HPS memory block through the ACP
// into an FPGA BRAM, one burst outstanding at a time, never crossing a 4 KB page.
module acp_read_to_bram
    import acp_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 128,
    parameter int              ID_W      = 8,
    parameter int              BRAM_AW   = 10,
    parameter logic [ID_W-1:0] AXI_ID    = '0,
    parameter logic [3:0]      ARCACHE_V = ACP_ARCACHE,
    parameter logic [4:0]      ARUSER_V  = ACP_ARUSER
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [31:0]        src_addr,
    input  logic [31:0]        byte_len,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               irq,
    output logic [ID_W-1:0]    arid,
    output logic [ADDR_W-1:0]  araddr,
    output logic [3:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic [1:0]         arlock,
    output logic [3:0]         arcache,
    output logic [2:0]         arprot,
    output logic [4:0]         aruser,
    output logic               arvalid,
    input  logic               arready,
    input  logic [ID_W-1:0]    rid,
    input  logic [DATA_W-1:0]  rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic [BRAM_AW-1:0] bram_addr,
    output logic [DATA_W-1:0]  bram_wdata,
    output logic               bram_we
);

    localparam int          RW    = BRAM_AW + 1;
    localparam logic [27:0] N_MAX = 28'(2 ** BRAM_AW);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, addr_nxt;
    logic [RW-1:0]       rem_q, rem_d, rem_nxt, n_start;
    logic [BRAM_AW-1:0]  ptr_q, ptr_d;
    logic [3:0]          beat_q, beat_d, arlen_q, arlen_d;
    logic                done_q, done_d, err_q, err_d;
    logic [4:0]          blen;
    logic                last_beat, beat_err;
    logic                unused_low;

    acp_burst_calc #(.ADDR_W(ADDR_W), .RW(RW)) u_calc (
        .addr_i (addr_q),
        .rem_i  (rem_q),
        .blen_o (blen),
        .rem_o  (rem_nxt),
        .addr_o (addr_nxt)
    );

    assign unused_low = ^{src_addr[3:0], byte_len[3:0]};
    assign n_start    = (byte_len[31:4] > N_MAX) ? RW'(N_MAX) : RW'(byte_len[31:4]);
    assign last_beat  = (beat_q == arlen_q);
    // rlast is only cross-checked; the beat counter alone closes the burst
    assign beat_err   = (rresp != AXI_RESP_OKAY) || (rid != AXI_ID) || (rlast != last_beat);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            arlen_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            arlen_q <= arlen_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        arlen_d = arlen_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: if (start) begin
                addr_d  = ADDR_W'({src_addr[31:4], 4'b0000});
                rem_d   = n_start;
                ptr_d   = '0;
                beat_d  = '0;
                done_d  = 1'b0;
                err_d   = 1'b0;
                state_d = (n_start == '0) ? S_FIN : S_CALC;
            end
            S_CALC: begin
                arlen_d = 4'(blen - 5'd1);
                state_d = S_ADDR;
            end
            S_ADDR: if (arready) state_d = S_DATA;
            S_DATA: if (rvalid) begin
                ptr_d  = ptr_q + 1'b1;
                beat_d = beat_q + 1'b1;
                err_d  = err_q | beat_err;
                if (last_beat) begin
                    beat_d  = '0;
                    rem_d   = rem_nxt;
                    addr_d  = addr_nxt;
                    state_d = (rem_nxt == '0) ? S_FIN : S_CALC;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q == S_CALC) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign done       = done_q | (state_q == S_FIN);
    assign err        = err_q;
    assign irq        = (state_q == S_FIN);
    assign arvalid    = (state_q == S_ADDR);
    assign rready     = (state_q == S_DATA);
    assign araddr     = addr_q;
    assign arlen      = arlen_q;
    assign bram_we    = rready & rvalid;
    assign bram_addr  = ptr_q;
    assign bram_wdata = bram_we ? rdata : '0;

    assign arid    = AXI_ID;
    assign arsize  = AXI_SIZE_16B;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = ARCACHE_V;
    assign arprot  = 3'b000;
    assign aruser  = ARUSER_V;

endmodule

// File: tb/tb_acp_read_to_bram.sv
// tb_acp_read_to_bram: directed scenarios against a behavioural ACP slave and BRAM model.
module tb_acp_read_to_bram;
    import acp_pkg::*;

    logic         clk, reset_n, start;
    logic [31:0]  src_addr, byte_len;
    logic         busy, done, err, irq;
    logic [7:0]   arid, rid;
    logic [31:0]  araddr;
    logic [3:0]   arlen, arcache;
    logic [2:0]   arsize, arprot;
    logic [1:0]   arburst, arlock, rresp;
    logic [4:0]   aruser;
    logic         arvalid, arready, rlast, rvalid, rready, bram_we;
    logic [127:0] rdata, bram_wdata;
    logic [9:0]   bram_addr;

    acp_read_to_bram dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .byte_len(byte_len),
        .busy(busy), .done(done), .err(err), .irq(irq),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .aruser(aruser),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int wr_cnt = 0, irq_cnt = 0, av_cnt = 0, nowrite_err = 0, stab_err = 0;
    int ar_dly_max = 0, gap_max = 0, slv_beat = -1;
    bit bad_rlast = 1'b0;
    logic [127:0] mem [0:1023];
    logic [31:0]  ar_addr_q[$];
    logic [3:0]   ar_len_q[$];
    logic [31:0]  sl_a;
    logic [3:0]   sl_l;
    int           sl_d, sl_g;

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a, ~a, a + 32'h1234_5678};
    endfunction

    function automatic int count_bad(input logic [31:0] base, input int n);
        int b = 0;
        for (int i = 0; i < n; i++) if (mem[i] !== pat(base + 32'(16 * i))) b++;
        return b;
    endfunction

    // BRAM model: capture at the negedge what the BRAM latches on the next posedge
    always @(negedge clk) begin
        if (bram_we) begin
            mem[bram_addr] = bram_wdata;
            wr_cnt++;
            if (!rvalid) nowrite_err++;
        end
        if (irq) irq_cnt++;
        if (arvalid) av_cnt++;
    end

    initial begin : slave
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00; rid = '0;
        forever begin
            @(posedge clk); #1;
            if (arvalid && reset_n) begin
                sl_a = araddr; sl_l = arlen;
                sl_d = $urandom_range(ar_dly_max, 0);
                repeat (sl_d) begin
                    @(posedge clk); #1;
                    if (araddr !== sl_a || arlen !== sl_l || arvalid !== 1'b1) stab_err++;
                end
                arready = 1'b1;
                @(posedge clk); #1;
                arready = 1'b0;
                ar_addr_q.push_back(sl_a);
                ar_len_q.push_back(sl_l);
                for (int b = 0; b <= int'(sl_l); b++) begin
                    sl_g = $urandom_range(gap_max, 0);
                    repeat (sl_g) begin @(posedge clk); #1; end
                    rvalid = 1'b1;
                    rdata  = pat(sl_a + 32'(16 * b));
                    rresp  = (b == slv_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    rlast  = (b == int'(sl_l)) || (bad_rlast && b == 0);
                    @(posedge clk); #1;
                    rvalid = 1'b0; rlast = 1'b0; rresp = AXI_RESP_OKAY;
                end
            end
        end
    end

    task automatic start_xfer(input logic [31:0] a, input logic [31:0] n);
        @(posedge clk); #1;
        src_addr = a; byte_len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int c = 0;
        while (done !== 1'b1 && c < lim) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, err, irq, arvalid, rready, bram_we} !== 7'b0) begin
            errors++; $display("FAIL reset_status: got %b expected 0000000", {busy, done, err, irq, arvalid, rready, bram_we});
        end
        checks++;
        if ({araddr, arlen, bram_addr} !== 46'b0) begin
            errors++; $display("FAIL reset_addr: got araddr=%h arlen=%h bram_addr=%h expected 0", araddr, arlen, bram_addr);
        end
        checks++;
        if ({arid, arsize, arburst, arlock, arcache, arprot, aruser} !== {8'h00, 3'b100, 2'b01, 2'b00, 4'hF, 3'b000, 5'b00001}) begin
            errors++; $display("FAIL reset_const: got %h expected %h", {arid, arsize, arburst, arlock, arcache, arprot, aruser},
                                {8'h00, 3'b100, 2'b01, 2'b00, 4'hF, 3'b000, 5'b00001});
        end
    endtask

    task automatic test_single;
        int w0 = wr_cnt, i0 = irq_cnt, s = ar_addr_q.size(), n = 0;
        ar_dly_max = 0; gap_max = 0;
        start_xfer(32'h0010_0000, 32'd64);
        while (n < 10) begin @(negedge clk); n++; if (arvalid) break; end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL arvalid_latency: got %0d cycles expected 2", n); end
        wait_done(200);
        checks++;
        if (ar_addr_q.size() - s !== 1 || ar_addr_q[s] !== 32'h0010_0000 || ar_len_q[s] !== 4'd3) begin
            errors++; $display("FAIL single_ar: got n=%0d addr=%h len=%0d expected 1 00100000 3", ar_addr_q.size() - s, ar_addr_q[s], ar_len_q[s]);
        end
        checks++;
        if (wr_cnt - w0 !== 4 || count_bad(32'h0010_0000, 4) !== 0) begin
            errors++; $display("FAIL single_bram: got %0d writes %0d bad expected 4 writes 0 bad", wr_cnt - w0, count_bad(32'h0010_0000, 4));
        end
        checks++;
        if (irq_cnt - i0 !== 1) begin errors++; $display("FAIL single_irq: got %0d cycles expected 1", irq_cnt - i0); end
        checks++;
        if ({done, err, busy} !== 3'b100) begin errors++; $display("FAIL single_status: got done/err/busy=%b expected 100", {done, err, busy}); end
    endtask

    task automatic test_multi;
        int w0 = wr_cnt, s = ar_addr_q.size();
        start_xfer(32'h2000_0000, 32'd512);
        wait_done(400);
        checks++;
        if (ar_addr_q.size() - s !== 2 || ar_addr_q[s] !== 32'h2000_0000 || ar_len_q[s] !== 4'd15 ||
            ar_addr_q[s+1] !== 32'h2000_0100 || ar_len_q[s+1] !== 4'd15) begin
            errors++; $display("FAIL multi_ar: got n=%0d %h/%0d %h/%0d expected 2 20000000/15 20000100/15",
                               ar_addr_q.size() - s, ar_addr_q[s], ar_len_q[s], ar_addr_q[s+1], ar_len_q[s+1]);
        end
        checks++;
        if (wr_cnt - w0 !== 32 || count_bad(32'h2000_0000, 32) !== 0) begin
            errors++; $display("FAIL multi_bram: got %0d writes %0d bad expected 32 writes 0 bad", wr_cnt - w0, count_bad(32'h2000_0000, 32));
        end
    endtask

    task automatic test_4k_cross;
        int w0 = wr_cnt, s = ar_addr_q.size();
        start_xfer(32'h0000_0FC0, 32'd128);
        wait_done(200);
        checks++;
        if (ar_addr_q.size() - s !== 2 || ar_addr_q[s] !== 32'h0000_0FC0 || ar_len_q[s] !== 4'd3 ||
            ar_addr_q[s+1] !== 32'h0000_1000 || ar_len_q[s+1] !== 4'd3) begin
            errors++; $display("FAIL 4k_ar: got n=%0d %h/%0d %h/%0d expected 2 00000fc0/3 00001000/3",
                               ar_addr_q.size() - s, ar_addr_q[s], ar_len_q[s], ar_addr_q[s+1], ar_len_q[s+1]);
        end
        checks++;
        if (wr_cnt - w0 !== 8 || count_bad(32'h0000_0FC0, 8) !== 0) begin
            errors++; $display("FAIL 4k_bram: got %0d writes %0d bad expected 8 writes 0 bad", wr_cnt - w0, count_bad(32'h0000_0FC0, 8));
        end
    endtask

    task automatic test_random_stall;
        int w0 = wr_cnt, s = ar_addr_q.size();
        ar_dly_max = 7; gap_max = 3;
        start_xfer(32'h3000_0040, 32'd640);
        wait_done(2000);
        ar_dly_max = 0; gap_max = 0;
        checks++;
        if (ar_addr_q.size() - s !== 3 || ar_addr_q[s] !== 32'h3000_0040 || ar_addr_q[s+1] !== 32'h3000_0140 ||
            ar_addr_q[s+2] !== 32'h3000_0240 || {ar_len_q[s], ar_len_q[s+1], ar_len_q[s+2]} !== {4'd15, 4'd15, 4'd7}) begin
            errors++; $display("FAIL random_ar: got n=%0d %h %h %h lens %h expected 3 30000040 30000140 30000240 lens ff7",
                               ar_addr_q.size() - s, ar_addr_q[s], ar_addr_q[s+1], ar_addr_q[s+2], {ar_len_q[s], ar_len_q[s+1], ar_len_q[s+2]});
        end
        checks++;
        if (stab_err !== 0) begin errors++; $display("FAIL ar_stable: got %0d unstable cycles expected 0", stab_err); end
        checks++;
        if (nowrite_err !== 0) begin errors++; $display("FAIL we_without_rvalid: got %0d expected 0", nowrite_err); end
        checks++;
        if (wr_cnt - w0 !== 40 || count_bad(32'h3000_0040, 40) !== 0 || {done, err} !== 2'b10) begin
            errors++; $display("FAIL random_bram: got %0d writes %0d bad done/err=%b expected 40 writes 0 bad 10",
                               wr_cnt - w0, count_bad(32'h3000_0040, 40), {done, err});
        end
    endtask

    task automatic test_clamp;
        int w0 = wr_cnt, s = ar_addr_q.size();
        start_xfer(32'h4000_0000, 32'h0002_0000);
        wait_done(5000);
        checks++;
        if (ar_addr_q.size() - s !== 64 || ar_addr_q[s+63] !== 32'h4000_3F00 || ar_len_q[s+63] !== 4'd15) begin
            errors++; $display("FAIL clamp_ar: got n=%0d last=%h/%0d expected 64 40003f00/15", ar_addr_q.size() - s, ar_addr_q[s+63], ar_len_q[s+63]);
        end
        checks++;
        if (wr_cnt - w0 !== 1024 || count_bad(32'h4000_0000, 1024) !== 0) begin
            errors++; $display("FAIL clamp_bram: got %0d writes %0d bad expected 1024 writes 0 bad", wr_cnt - w0, count_bad(32'h4000_0000, 1024));
        end
    endtask

    task automatic test_slverr;
        int w0 = wr_cnt, s = ar_addr_q.size(), c = 0;
        slv_beat = 1;
        start_xfer(32'h0050_0000, 32'd64);
        while (rready !== 1'b1 && c < 50) begin @(negedge clk); c++; end
        start_xfer(32'h0060_0000, 32'd64);
        wait_done(200);
        repeat (5) @(negedge clk);
        slv_beat = -1;
        checks++;
        if (wr_cnt - w0 !== 4 || count_bad(32'h0050_0000, 4) !== 0) begin
            errors++; $display("FAIL slverr_bram: got %0d writes %0d bad expected 4 writes 0 bad", wr_cnt - w0, count_bad(32'h0050_0000, 4));
        end
        checks++;
        if ({done, err, busy} !== 3'b110) begin errors++; $display("FAIL slverr_status: got done/err/busy=%b expected 110", {done, err, busy}); end
        checks++;
        if (ar_addr_q.size() - s !== 1) begin errors++; $display("FAIL start_in_data: got %0d ARs expected 1", ar_addr_q.size() - s); end
    endtask

    task automatic test_rlast_err;
        int w0 = wr_cnt;
        bad_rlast = 1'b1;
        start_xfer(32'h0070_0000, 32'd64);
        wait_done(200);
        bad_rlast = 1'b0;
        checks++;
        if (wr_cnt - w0 !== 4 || {done, err} !== 2'b11) begin
            errors++; $display("FAIL rlast_early: got %0d writes done/err=%b expected 4 writes 11", wr_cnt - w0, {done, err});
        end
    endtask

    task automatic test_zero_len;
        int i0 = irq_cnt, a0 = av_cnt, w0 = wr_cnt, n = 0;
        start_xfer(32'h0000_1230, 32'd8);
        while (done !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        checks++;
        if (n > 2) begin errors++; $display("FAIL zero_latency: got %0d cycles expected <=2", n); end
        repeat (4) @(negedge clk);
        checks++;
        if (irq_cnt - i0 !== 1 || av_cnt - a0 !== 0 || wr_cnt - w0 !== 0) begin
            errors++; $display("FAIL zero_bus: got irq=%0d arvalid=%0d writes=%0d expected 1 0 0", irq_cnt - i0, av_cnt - a0, wr_cnt - w0);
        end
        checks++;
        if ({done, err, busy} !== 3'b100) begin errors++; $display("FAIL zero_status: got done/err/busy=%b expected 100", {done, err, busy}); end
    endtask

    task automatic test_back_to_back;
        int w0 = wr_cnt, i0 = irq_cnt, s = ar_addr_q.size(), c = 0;
        start_xfer(32'h0800_0000, 32'd64);
        while (irq !== 1'b1 && c < 200) begin @(negedge clk); c++; end
        @(posedge clk); #1;
        src_addr = 32'h0900_0000; byte_len = 32'd64; start = 1'b1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_held: got %b expected 1", done); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b01) begin errors++; $display("FAIL b2b_accept: got done/busy=%b expected 01", {done, busy}); end
        wait_done(200);
        checks++;
        if (ar_addr_q.size() - s !== 2 || ar_addr_q[s+1] !== 32'h0900_0000 || wr_cnt - w0 !== 8 ||
            irq_cnt - i0 !== 2 || count_bad(32'h0900_0000, 4) !== 0) begin
            errors++; $display("FAIL b2b_xfer: got ARs=%0d addr=%h writes=%0d irqs=%0d bad=%0d expected 2 09000000 8 2 0",
                               ar_addr_q.size() - s, ar_addr_q[s+1], wr_cnt - w0, irq_cnt - i0, count_bad(32'h0900_0000, 4));
        end
    endtask

    task automatic test_reset_mid;
        int w0 = wr_cnt, c = 0, s;
        gap_max = 2;
        start_xfer(32'h0A00_0000, 32'd256);
        while (wr_cnt - w0 < 3 && c < 200) begin @(negedge clk); c++; end
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, arvalid, rready, bram_we, done, irq} !== 6'b0) begin
            errors++; $display("FAIL async_reset: got %b expected 000000", {busy, arvalid, rready, bram_we, done, irq});
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (100) @(negedge clk);
        gap_max = 0;
        w0 = wr_cnt; s = ar_addr_q.size();
        start_xfer(32'h0B00_0000, 32'd64);
        wait_done(200);
        checks++;
        if (ar_addr_q.size() - s !== 1 || wr_cnt - w0 !== 4 || count_bad(32'h0B00_0000, 4) !== 0 || {done, err} !== 2'b10) begin
            errors++; $display("FAIL after_reset: got ARs=%0d writes=%0d bad=%0d done/err=%b expected 1 4 0 10",
                               ar_addr_q.size() - s, wr_cnt - w0, count_bad(32'h0B00_0000, 4), {done, err});
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; src_addr = '0; byte_len = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        reset_n = 1'b1;
        test_single;
        test_multi;
        test_4k_cross;
        test_random_stall;
        test_clamp;
        test_slverr;
        test_rlast_err;
        test_zero_len;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acp_read_to_bram.md
Name: acp_read_to_bram

Overview:
- AXI3 read master on the FPGA-to-HPS slave. Fetches a contiguous block of HPS memory through the ACP (cache-coherent) and writes it into an FPGA BRAM.
- It is the reverse-direction counterpart of the s0 BRAM-to-HPS stream engine and shares the same addr/len/rdy PIO handshake.
- One burst is outstanding at a time. Bursts never cross a 4 KB boundary.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 128, AXI/BRAM data width (16 bytes per beat)
- ID_W, 8, AXI ID width
- BRAM_AW, 10, BRAM word-address width (capacity 2^BRAM_AW beats)
- AXI_ID, 0, constant arid value
- ARCACHE_V, 4'b1111, ACP coherent write-back allocate
- ARUSER_V, 5'b00001, ACP shared/coherent sideband

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- start  in  1  one-cycle start pulse (from rdy PIO edge)
- src_addr  in  32  HPS byte address; bits [3:0] ignored
- byte_len  in  32  transfer length in bytes; bits [3:0] ignored
- busy  out  1  transfer in progress
- done  out  1  sticky completion flag, cleared by next start
- err  out  1  sticky: a non-OKAY rresp was seen during the current transfer
- irq  out  1  one-cycle pulse at completion
- arid  out  ID_W
- araddr  out  32
- arlen  out  4
- arsize  out  3
- arburst  out  2
- arlock  out  2
- arcache  out  4
- arprot  out  3
- aruser  out  5
- arvalid  out  1
- arready  in  1
- rid  in  ID_W
- rdata  in  128
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1
- bram_addr  out  BRAM_AW  BRAM word address
- bram_wdata  out  128  BRAM write data
- bram_we  out  1  BRAM write enable

Behaviour:
- Reset values: all outputs 0 except the constant fields: arid=AXI_ID, arsize=3'b100, arburst=2'b01 (INCR), arlock=0, arcache=ARCACHE_V, arprot=0, aruser=ARUSER_V. Reset is asynchronous.
- Reset mid-burst: all state and outputs go to reset values immediately. The top level resets the HPS bridge together with this block, so no bus recovery is required.
- Transfer setup:
  - Beat count N = byte_len[31:4], clamped to 2^BRAM_AW.
  - Current address = {src_addr[31:4], 4'b0}.
  - BRAM pointer starts at 0.
- FSM states: IDLE, CALC, ADDR, DATA, FIN.
- IDLE:
  - start is sampled only here. On start: latch inputs, clear done and err, set busy.
  - If N=0, go to FIN; otherwise go to CALC.
  - start is ignored in all other states.
- CALC: burst length B = min(16, remaining, 256 - addr[11:4]). Register arlen = B-1, then go to ADDR.
- ADDR:
  - arvalid=1; araddr and arlen held stable until arready.
  - On arvalid & arready: drop arvalid and go to DATA.
  - arvalid is asserted the cycle after CALC, i.e. two cycles after start.
- DATA:
  - rready=1 for the whole state.
  - Each rvalid & rready beat: bram_we=1, bram_wdata=rdata, bram_addr=pointer; then increment the pointer.
  - Write is combinational from the handshake. The BRAM port is registered at the BRAM.
  - If rresp != 2'b00, set err; data is still written.
  - A beat with rid != AXI_ID also sets err.
  - On the beat counter reaching B (rlast expected): remaining -= B, addr += 16*B. Go to FIN if remaining = 0, else CALC.
  - rlast arriving early or late sets err. The beat counter, not rlast, ends the burst.
- FIN: busy=0, done=1, irq=1 for exactly one cycle, then IDLE.
- Width rules:
  - addr += B<<4 in 32-bit modular arithmetic; wrap past 0xFFFF_FFFF is not checked.
  - The BRAM pointer does not wrap, because N is clamped.
- Back-to-back: a start on the cycle after FIN is accepted. done stays high until that start.

Decomposition:
- Package acp_pkg holds:
  - AXI burst/resp encodings (INCR, OKAY, SLVERR, DECERR)
  - ACP cache/user constants
  - size code 3'b100
  - FSM state enum
  - beat-bytes constant 16
  - 4 KB page beats constant 256
- Sub-module acp_burst_calc (combinational min of three terms, remaining/addr update) is natural and is reused by the write-direction engine.

Test Plan:
- src_addr 0x0010_0000, byte_len 64, arready immediate → one AR (araddr 0x0010_0000, arlen 3); 4 BRAM writes at addr 0..3 with matching data; irq one cycle; done=1, err=0.
- byte_len 512 from 0x2000_0000 → two ARs: 0x2000_0000 arlen 15, then 0x2000_0100 arlen 15; 32 writes at BRAM addr 0..31.
- 4 KB crossing: src_addr 0x0000_0FC0, byte_len 128 → AR 0xFC0 arlen 3, then AR 0x1000 arlen 3; 8 writes.
- Random arready delay 0-7 cycles and random rvalid gaps → araddr/arlen stable while arvalid is high; BRAM contents exactly equal the source pattern; no writes without rvalid.
- rresp=SLVERR on beat 2 of 4 → all 4 beats still written, err=1, done=1. A start during DATA is ignored.
- byte_len 8 (N=0) → done and irq within 2 cycles, arvalid never asserted.
- reset_n low mid-DATA → busy, arvalid, rready, bram_we, done, irq all 0 asynchronously; a fresh start after release completes normally.
